note_stack: RTL and testbench
=============================

NOTE_STACK -- requirements
Module: note_stack

Interface
REQ-001 Parameter DEPTH, default 8: number of held-note stack entries, range 2..15.
REQ-002 Parameter ID_W, default 7: note-id width; the message width is ID_W+1.
REQ-003 clk_msg  input  1  block clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  one-cycle strobe qualifying in_msg, max one message per cycle.
REQ-006 in_msg  input  8  keyboard message: bit7=1 note-on, bit7=0 note-off, bits6:0 note id.
REQ-007 clear  input  1  synchronous release-all request.
REQ-008 out_valid  output  1  one-cycle strobe qualifying out_msg, toward the player.
REQ-009 out_msg  output  8  player message, same format as in_msg.
REQ-010 active_note  output  7  id at stack top; 0 when the stack is empty.
REQ-011 count  output  4  number of held notes, 0..DEPTH.
REQ-012 overflow  output  1  one-cycle pulse when a note-on evicts the oldest entry.

Function
REQ-013 The block SHALL keep a last-note-priority stack, entry[0] oldest and entry[count-1] the top, with no duplicate ids.
REQ-014 Note id 0 is reserved; any input message with id 0 SHALL be ignored, with no state change and no output.
REQ-015 Note-on X, X absent, count<DEPTH: push X; emit {1,X}.
REQ-016 Note-on X, X absent, count==DEPTH: drop entry[0], shift the remaining entries down, push X, and pulse overflow; emit {1,X}; count stays DEPTH.
REQ-017 Note-on X, X present but not top: remove X, compact, and re-push X at the top; emit {1,X}; count unchanged.
REQ-018 Note-on X, X already top: no state change and no output.
REQ-019 Note-off X, X absent: ignored, no output.
REQ-020 Note-off X, X present but not top: remove X and compact order-preservingly; no output.
REQ-021 Note-off X, X is top, count>1 before the update: pop X; emit {1,new top} (fall back to the previous key).
REQ-022 Note-off X, X is top, count==1 before the update: pop X; emit {0,X}; count becomes 0.
REQ-023 clear with a non-empty stack: empty the stack; emit {0,old top}. With an empty stack: no output.
REQ-024 clear and in_valid in the same cycle: clear wins and the input message is dropped.
REQ-025 Latency: out_valid and out_msg SHALL be registered and assert exactly 1 cycle after the qualifying in_valid or clear edge.
REQ-026 out_valid SHALL be high for exactly one cycle per emitted message.
REQ-027 out_msg SHALL hold its last value while out_valid is low.
REQ-028 Throughput SHALL be one message per cycle; back-to-back in_valid cycles SHALL each be fully processed in order.
REQ-029 active_note and count SHALL be registered and reflect the stack after the update, aligned with out_valid.
REQ-030 The id search SHALL compare all DEPTH entries in parallel within one cycle; entries at index >= count SHALL never match.

Reset
REQ-031 While rst is high, the block SHALL hold count=0, all entries=0, active_note=0, out_valid=0, out_msg=8'h00, overflow=0.
REQ-032 Assertion of rst mid-operation SHALL discard the stack immediately, with no release message emitted.
REQ-033 The first in_valid on the first clk_msg edge after rst deasserts SHALL be processed normally.

Verification
REQ-034 Reset, then note-on 5, note-on 9, note-off 9 -> outputs 8'h85, 8'h89, 8'h85; count ends at 1; active_note=5.
REQ-035 From {5,9,12} (12 top): note-off 9 -> no out_valid and count=2; then note-off 12 -> 8'h85; then note-off 5 -> 8'h05 and count=0.
REQ-036 DEPTH=8: push ids 1..8, then note-on 20 -> overflow pulse, out 8'h94, count=8; a later note-off 1 -> no output (id 1 was evicted).
REQ-037 From {3,4}: note-on 3 -> 8'h83 with top=3; a further note-on 3 -> no output; note-on 0 -> ignored.
REQ-038 From {7}: clear together with in_valid note-on 2 -> out 8'h07, count=0, note-on 2 dropped; then rst pulsed during a held stack -> all outputs zero and no out_valid.

Source files
------------

// File: rtl/note_stack.sv
// Last-note-priority held-note stack: keyboard note on/off messages in,
// player messages out. The newest held note sounds; releasing it falls back to the previous key.
module note_stack #(
  parameter int DEPTH = 8,
  parameter int ID_W  = 7
) (
  input  logic            clk_msg,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [ID_W:0]   in_msg,
  input  logic            clear,
  output logic            out_valid,
  output logic [ID_W:0]   out_msg,
  output logic [ID_W-1:0] active_note,
  output logic [3:0]      count,
  output logic            overflow
);

  logic [ID_W-1:0] ent_r     [DEPTH];
  logic [ID_W-1:0] nxt_ent_s [DEPTH];
  logic [ID_W-1:0] sh_s      [DEPTH];
  logic [ID_W-1:0] rem_s     [DEPTH];

  logic [3:0]       cnt_r, nxt_cnt_s, hit_idx_s;
  logic [DEPTH-1:0] match_s;
  logic             hit_s, is_top_s, on_s;
  logic [ID_W-1:0]  id_s, top_s, second_s, nxt_top_s;

  logic             emit_s, ovf_s;
  logic [ID_W:0]    emsg_s;
  logic             out_valid_r, overflow_r;
  logic [ID_W:0]    out_msg_r;
  logic [ID_W-1:0]  active_r;

  // Parallel id search plus the shifted / compacted views of the stack.
  // Slots at or above the count are kept at zero, so the shifted view stays clean.
  always_comb begin
    id_s      = in_msg[ID_W-1:0];
    on_s      = in_msg[ID_W];
    match_s   = {DEPTH{1'b0}};
    hit_idx_s = 4'd0;
    top_s     = {ID_W{1'b0}};
    second_s  = {ID_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = (i < int'(cnt_r)) && (ent_r[i] == id_s);
      hit_idx_s  = match_s[i] ? 4'(i) : hit_idx_s;
      top_s      = (i + 1 == int'(cnt_r)) ? ent_r[i] : top_s;
      second_s   = (i + 2 == int'(cnt_r)) ? ent_r[i] : second_s;
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      sh_s[i] = ent_r[i+1];
    end
    sh_s[DEPTH-1] = {ID_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rem_s[i] = (i >= int'(hit_idx_s)) ? sh_s[i] : ent_r[i];
    end
    hit_s    = |match_s;
    is_top_s = hit_s && (int'(hit_idx_s) + 1 == int'(cnt_r));
  end

  // Stack update and message selection; clear takes priority over the input message.
  always_comb begin
    nxt_ent_s = ent_r;
    nxt_cnt_s = cnt_r;
    emit_s    = 1'b0;
    ovf_s     = 1'b0;
    emsg_s    = out_msg_r;
    nxt_top_s = {ID_W{1'b0}};
    if (clear) begin
      if (cnt_r != 4'd0) begin
        for (int i = 0; i < DEPTH; i++) begin
          nxt_ent_s[i] = {ID_W{1'b0}};
        end
        nxt_cnt_s = 4'd0;
        emit_s    = 1'b1;
        emsg_s    = {1'b0, top_s};
      end else begin
        nxt_cnt_s = cnt_r;
      end
    end else if (in_valid && (id_s != {ID_W{1'b0}})) begin
      if (on_s) begin
        if (is_top_s) begin
          nxt_cnt_s = cnt_r;
        end else if (hit_s) begin
          for (int i = 0; i < DEPTH; i++) begin
            nxt_ent_s[i] = (i + 1 == int'(cnt_r)) ? id_s : rem_s[i];
          end
          emit_s = 1'b1;
          emsg_s = {1'b1, id_s};
        end else if (int'(cnt_r) < DEPTH) begin
          for (int i = 0; i < DEPTH; i++) begin
            nxt_ent_s[i] = (i == int'(cnt_r)) ? id_s : ent_r[i];
          end
          nxt_cnt_s = cnt_r + 4'd1;
          emit_s    = 1'b1;
          emsg_s    = {1'b1, id_s};
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            nxt_ent_s[i] = (i == DEPTH - 1) ? id_s : sh_s[i];
          end
          ovf_s  = 1'b1;
          emit_s = 1'b1;
          emsg_s = {1'b1, id_s};
        end
      end else begin
        if (!hit_s) begin
          nxt_cnt_s = cnt_r;
        end else begin
          nxt_ent_s = rem_s;
          nxt_cnt_s = cnt_r - 4'd1;
          if (!is_top_s) begin
            emit_s = 1'b0;
          end else if (cnt_r > 4'd1) begin
            emit_s = 1'b1;
            emsg_s = {1'b1, second_s};
          end else begin
            emit_s = 1'b1;
            emsg_s = {1'b0, id_s};
          end
        end
      end
    end else begin
      nxt_cnt_s = cnt_r;
    end
    for (int i = 0; i < DEPTH; i++) begin
      nxt_top_s = (i + 1 == int'(nxt_cnt_s)) ? nxt_ent_s[i] : nxt_top_s;
    end
  end

  // State and registered outputs; out_msg keeps its last value between strobes.
  always_ff @(posedge clk_msg or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= {ID_W{1'b0}};
      end
      cnt_r       <= 4'd0;
      out_valid_r <= 1'b0;
      out_msg_r   <= {(ID_W+1){1'b0}};
      overflow_r  <= 1'b0;
      active_r    <= {ID_W{1'b0}};
    end else begin
      ent_r       <= nxt_ent_s;
      cnt_r       <= nxt_cnt_s;
      out_valid_r <= emit_s;
      out_msg_r   <= emsg_s;
      overflow_r  <= ovf_s;
      active_r    <= nxt_top_s;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_msg     = out_msg_r;
  assign overflow    = overflow_r;
  assign active_note = active_r;
  assign count       = cnt_r;

endmodule

// File: tb/tb_note_stack.sv
// Scoreboard bench for note_stack: directed note on/off/clear/reset vectors,
// expected player messages queued with their due cycle and checked by a monitor.
module tb_note_stack;

  logic       clk_msg = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_msg;
  logic       clear;
  logic       out_valid;
  logic [7:0] out_msg;
  logic [6:0] active_note;
  logic [3:0] count;
  logic       overflow;

  typedef struct {
    logic [7:0] msg;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  note_stack #(.DEPTH(8), .ID_W(7)) dut (
    .clk_msg(clk_msg), .rst(rst), .in_valid(in_valid), .in_msg(in_msg),
    .clear(clear), .out_valid(out_valid), .out_msg(out_msg),
    .active_note(active_note), .count(count), .overflow(overflow)
  );

  always #5 clk_msg = ~clk_msg;

  always @(posedge clk_msg) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the queue head and arrive on its due cycle.
  always @(negedge clk_msg) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", int'(out_msg), 'h1FF);
        end else begin
          chk("out_msg", int'(out_msg), int'(exp_q[0].msg));
          chk("out_latency", cyc, exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        chk("missing_out", 0, int'(exp_q[0].msg) + 'h100);
        void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus, entered and left on a falling edge.
  task automatic step(input logic v, input logic [7:0] m, input logic c,
                      input bit e, input logic [7:0] em);
    exp_t x;
    in_valid = v;
    in_msg   = m;
    clear    = c;
    if (e) begin
      x.msg = em;
      x.due = cyc + 1;
      exp_q.push_back(x);
    end
    @(negedge clk_msg);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic on(input int id, input bit e);
    step(1'b1, 8'h80 | 8'(id), 1'b0, e, 8'h80 | 8'(id));
  endtask

  task automatic off(input int id, input bit e, input logic [7:0] em);
    step(1'b1, 8'(id), 1'b0, e, em);
  endtask

  task automatic chk_state(input string name, input int c, input int a);
    chk({name, "_count"}, int'(count), c);
    chk({name, "_active"}, int'(active_note), a);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_msg = 8'h00; clear = 1'b0;
    repeat (2) @(negedge clk_msg);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_msg", int'(out_msg), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk_state("rst", 0, 0);
    rst = 1'b0;

    // fallback to previous key; first message right after reset release
    on(5, 1'b1); on(9, 1'b1);
    off(9, 1'b1, 8'h85);
    chk_state("fallback", 1, 5);

    // release of a buried note is silent; last release emits note-off
    on(9, 1'b1); on(12, 1'b1);
    off(9, 1'b0, 8'h00);
    chk_state("buried_off", 2, 12);
    chk("hold_out_msg", int'(out_msg), 'h8C);
    off(12, 1'b1, 8'h85);
    off(5, 1'b1, 8'h05);
    chk_state("empty", 0, 0);

    // eviction of the oldest entry when full
    for (int i = 1; i <= 8; i++) on(i, 1'b1);
    chk_state("full", 8, 8);
    on(20, 1'b1);
    chk("overflow_pulse", int'(overflow), 1);
    chk_state("evict", 8, 20);
    off(1, 1'b0, 8'h00);
    chk("overflow_drop", int'(overflow), 0);
    chk_state("evicted_off", 8, 20);
    off(2, 1'b0, 8'h00);
    chk_state("compact", 7, 20);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h14);
    chk_state("clear", 0, 0);

    // re-press moves to top; repeated top and id 0 are ignored
    on(3, 1'b1); on(4, 1'b1); on(3, 1'b1);
    chk_state("repush", 2, 3);
    on(3, 1'b0);
    step(1'b1, 8'h80, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    chk_state("ignored", 2, 3);
    off(3, 1'b1, 8'h84);
    chk_state("fallback2", 1, 4);
    off(4, 1'b1, 8'h04);

    // clear beats a simultaneous note-on
    on(7, 1'b1);
    step(1'b1, 8'h82, 1'b1, 1'b1, 8'h07);
    chk_state("clear_wins", 0, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // asynchronous reset discards a held stack silently
    on(5, 1'b1); on(6, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_msg", int'(out_msg), 0);
    chk_state("mid_rst", 0, 0);
    repeat (2) @(negedge clk_msg);
    chk("mid_rst_hold_valid", int'(out_valid), 0);
    rst = 1'b0;
    off(5, 1'b0, 8'h00);
    on(6, 1'b1);
    chk_state("after_rst", 1, 6);

    repeat (2) @(negedge clk_msg);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
